// File: rtl/cordic_rr_sched.sv
// rtl/cordic_rr_sched.sv - round-robin scheduler sharing one external sin/cos CORDIC pipeline
module cordic_rr_sched #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int PIPE_LAT = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_vld,
    input  logic [9*N_REQ-1:0]   req_angle,
    output logic [N_REQ-1:0]     req_rdy,
    output logic [8:0]           cordic_angle,
    output logic                 cordic_vld,
    input  logic [31:0]          cordic_sin,
    input  logic [31:0]          cordic_cos,
    output logic                 rsp_vld,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_sin,
    output logic [31:0]          rsp_cos,
    output logic                 idle
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt;
    logic [ID_W:0]   cand;

    logic [8:0]      sel_angle;
    logic [8:0]      red_angle;
    logic [8:0]      fold_angle;
    logic [1:0]      quad;

    // Tag stage 0 is the issue register; stage PIPE_LAT lines up with the datapath result.
    logic [PIPE_LAT:0] tag_vld;
    logic [ID_W-1:0]   tag_id [0:PIPE_LAT];
    logic [1:0]        tag_q  [0:PIPE_LAT];

    // Cyclic search from ptr: walk candidates from farthest to nearest so the nearest wins.
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (req_vld[cand[ID_W-1:0]]) begin
                gnt     = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
        // No grants while reset is held, regardless of en.
        gnt = gnt & en & rst_n;
    end

    // One-hot accept for the winning requester.
    always_comb begin
        req_rdy = '0;
        if (gnt) begin
            req_rdy[gnt_idx] = 1'b1;
        end
    end

    // Select the winner's angle, reduce mod 360 (single pass suffices for 0..511) and fold to 0..90.
    always_comb begin
        sel_angle = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_angle = req_angle[9*i +: 9];
            end
        end
        red_angle = (sel_angle >= 9'd360) ? (sel_angle - 9'd360) : sel_angle;
        if (red_angle <= 9'd90) begin
            fold_angle = red_angle;
            quad       = 2'd0;
        end else if (red_angle <= 9'd180) begin
            fold_angle = 9'd180 - red_angle;
            quad       = 2'd1;
        end else if (red_angle <= 9'd270) begin
            fold_angle = red_angle - 9'd180;
            quad       = 2'd2;
        end else begin
            fold_angle = 9'd360 - red_angle;
            quad       = 2'd3;
        end
    end

    // Round-robin pointer moves just past the last granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt) begin
            ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Issue register plus tag shift line tracking each in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cordic_angle <= '0;
            cordic_vld   <= 1'b0;
            tag_vld      <= '0;
            for (int i = 0; i <= PIPE_LAT; i++) begin
                tag_id[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            cordic_vld <= gnt;
            tag_vld[0] <= gnt;
            if (gnt) begin
                cordic_angle <= fold_angle;
                tag_id[0]    <= gnt_idx;
                tag_q[0]     <= quad;
            end
            for (int i = 1; i <= PIPE_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    // Sign-correct the returning result by quadrant; outputs hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld <= 1'b0;
            rsp_id  <= '0;
            rsp_sin <= '0;
            rsp_cos <= '0;
        end else begin
            rsp_vld <= tag_vld[PIPE_LAT];
            if (tag_vld[PIPE_LAT]) begin
                rsp_id  <= tag_id[PIPE_LAT];
                rsp_sin <= tag_q[PIPE_LAT][1] ? (~cordic_sin + 32'd1) : cordic_sin;
                rsp_cos <= (^tag_q[PIPE_LAT]) ? (~cordic_cos + 32'd1) : cordic_cos;
            end
        end
    end

    assign idle = ~cordic_vld & ~(|tag_vld);

endmodule

// File: tb/tb_cordic_rr_sched.sv
// tb/tb_cordic_rr_sched.sv - self-checking bench for cordic_rr_sched
module tb_cordic_rr_sched;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int PIPE_LAT = 18;
    localparam int LAT      = PIPE_LAT + 2;
    localparam int TOL      = 128;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [N_REQ-1:0]     req_vld;
    logic [9*N_REQ-1:0]   req_angle;
    logic [N_REQ-1:0]     req_rdy;
    logic [8:0]           cordic_angle;
    logic                 cordic_vld;
    logic [31:0]          cordic_sin;
    logic [31:0]          cordic_cos;
    logic                 rsp_vld;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_sin;
    logic [31:0]          rsp_cos;
    logic                 idle;

    cordic_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_vld(req_vld), .req_angle(req_angle), .req_rdy(req_rdy),
        .cordic_angle(cordic_angle), .cordic_vld(cordic_vld),
        .cordic_sin(cordic_sin), .cordic_cos(cordic_cos),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fx_sin(input int deg);
        real r;
        r = real'(deg) * 3.14159265358979 / 180.0;
        return $rtoi($floor(65536.0 * $sin(r) + 0.5));
    endfunction

    function automatic int fx_cos(input int deg);
        real r;
        r = real'(deg) * 3.14159265358979 / 180.0;
        return $rtoi($floor(65536.0 * $cos(r) + 0.5));
    endfunction

    function automatic bit near(input int a, input int b);
        return ((a - b) <= TOL) && ((b - a) <= TOL);
    endfunction

    // External CORDIC pipeline stand-in: result appears PIPE_LAT cycles after the angle.
    logic [31:0] ps [0:PIPE_LAT-1];
    logic [31:0] pc [0:PIPE_LAT-1];
    always @(posedge clk) begin
        ps[0] <= fx_sin(int'(cordic_angle));
        pc[0] <= fx_cos(int'(cordic_angle));
        for (int k = 1; k < PIPE_LAT; k++) begin
            ps[k] <= ps[k-1];
            pc[k] <= pc[k-1];
        end
    end
    assign cordic_sin = ps[PIPE_LAT-1];
    assign cordic_cos = pc[PIPE_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    typedef struct {int id; int s; int c; int due;} exp_t;
    exp_t exp_q[$];
    int   m_ptr = 0;
    bit   pend_vld = 0;
    int   pend_fold = 0;
    int   last_s = 0;
    int   last_c = 0;

    int grant_log[$];
    int fold_log[$];
    int rsp_id_log[$];
    int rsp_s_log[$];
    int rsp_c_log[$];

    always @(negedge clk) begin
        exp_t e;
        int g, a, idx, f;
        bit idle_exp;
        logic [N_REQ-1:0] rdy_exp;
        if (!rst_n) begin
            chk(req_rdy == '0, "rst_req_rdy", int'(req_rdy), 0);
            chk(cordic_vld == 1'b0, "rst_cordic_vld", int'(cordic_vld), 0);
            chk(cordic_angle == '0, "rst_cordic_angle", int'(cordic_angle), 0);
            chk(rsp_vld == 1'b0, "rst_rsp_vld", int'(rsp_vld), 0);
            chk(rsp_id == '0, "rst_rsp_id", int'(rsp_id), 0);
            chk(rsp_sin == '0 && rsp_cos == '0, "rst_rsp_data", int'(rsp_sin), 0);
            chk(idle == 1'b1, "rst_idle", int'(idle), 1);
            exp_q.delete();
            m_ptr = 0; pend_vld = 0; last_s = 0; last_c = 0;
        end else begin
            idle_exp = (exp_q.size() == 0) || (exp_q[$].due <= cyc);
            chk(idle == idle_exp, "idle", int'(idle), int'(idle_exp));

            chk(cordic_vld == pend_vld, "cordic_vld", int'(cordic_vld), int'(pend_vld));
            if (pend_vld) begin
                chk(int'(cordic_angle) == pend_fold, "cordic_angle", int'(cordic_angle), pend_fold);
                fold_log.push_back(int'(cordic_angle));
            end

            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk(rsp_vld == 1'b1, "rsp_vld_due", int'(rsp_vld), 1);
                chk(int'(rsp_id) == e.id, "rsp_id", int'(rsp_id), e.id);
                chk(near($signed(rsp_sin), e.s), "rsp_sin", $signed(rsp_sin), e.s);
                chk(near($signed(rsp_cos), e.c), "rsp_cos", $signed(rsp_cos), e.c);
                last_s = e.s; last_c = e.c;
            end else begin
                chk(rsp_vld == 1'b0, "rsp_vld_quiet", int'(rsp_vld), 0);
                chk(near($signed(rsp_sin), last_s) && near($signed(rsp_cos), last_c),
                    "rsp_hold", $signed(rsp_sin), last_s);
            end
            if (rsp_vld) begin
                rsp_id_log.push_back(int'(rsp_id));
                rsp_s_log.push_back($signed(rsp_sin));
                rsp_c_log.push_back($signed(rsp_cos));
            end

            g = -1;
            if (en) begin
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    idx = (m_ptr + k) % N_REQ;
                    if (req_vld[idx]) g = idx;
                end
            end
            rdy_exp = '0;
            if (g >= 0) rdy_exp[g] = 1'b1;
            chk(req_rdy == rdy_exp, "req_rdy", int'(req_rdy), int'(rdy_exp));

            pend_vld = 0;
            if (g >= 0) begin
                a = int'(req_angle[9*g +: 9]) % 360;
                if (a <= 90)       f = a;
                else if (a <= 180) f = 180 - a;
                else if (a <= 270) f = a - 180;
                else               f = 360 - a;
                pend_vld  = 1;
                pend_fold = f;
                e.id = g; e.s = fx_sin(a); e.c = fx_cos(a); e.due = cyc + LAT;
                exp_q.push_back(e);
                m_ptr = (g + 1) % N_REQ;
                grant_log.push_back(g);
            end
        end
    end

    typedef struct {int id; int ang; int fold; int s; int c;} vec_t;
    vec_t tbl[$];

    task automatic clear_logs();
        grant_log.delete(); fold_log.delete();
        rsp_id_log.delete(); rsp_s_log.delete(); rsp_c_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // Present one request from a single requester and wait (bounded) for its accept.
    task automatic issue(input int id, input int ang);
        bit got;
        got = 0;
        req_vld = '0;
        req_vld[id] = 1'b1;
        req_angle[9*id +: 9] = 9'(ang);
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req_rdy[id]) got = 1;
        end
        if (!got) chk(1'b0, "accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, k, cnt;
        rst_n = 1'b0; en = 1'b0; req_vld = '0; req_angle = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven single-requester vectors, back to back.
        tbl.push_back('{0,  30, 30,  32768,  56756});
        tbl.push_back('{1, 150, 30,  32768, -56756});
        tbl.push_back('{1, 210, 30, -32768, -56756});
        tbl.push_back('{1, 330, 30, -32768,  56756});
        tbl.push_back('{1,  90, 90,  65536,      0});
        tbl.push_back('{2, 400, 40,  42125,  50203});
        tbl.push_back('{3, 360,  0,      0,  65536});
        tbl.push_back('{3, 511, 29,  31773, -57318});
        tbl.push_back('{0, 180,  0,      0, -65536});
        tbl.push_back('{1, 270, 90, -65536,      0});
        tbl.push_back('{2,   0,  0,      0,  65536});
        tbl.push_back('{3, 271, 89, -65526,   1144});
        tbl.push_back('{2, 181,  1,  -1144, -65526});
        clear_logs();
        en = 1'b1;
        foreach (tbl[i]) issue(tbl[i].id, tbl[i].ang);
        req_vld = '0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        n = tbl.size();
        chk(fold_log.size() == n, "tbl_fold_count", fold_log.size(), n);
        chk(rsp_id_log.size() == n, "tbl_rsp_count", rsp_id_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < fold_log.size())
                chk(fold_log[i] == tbl[i].fold, "tbl_fold", fold_log[i], tbl[i].fold);
            if (i < rsp_id_log.size()) begin
                chk(rsp_id_log[i] == tbl[i].id, "tbl_id", rsp_id_log[i], tbl[i].id);
                chk(near(rsp_s_log[i], tbl[i].s), "tbl_sin", rsp_s_log[i], tbl[i].s);
                chk(near(rsp_c_log[i], tbl[i].c), "tbl_cos", rsp_c_log[i], tbl[i].c);
            end
        end

        // Round-robin: all four, then only ids 1 and 3.
        do_reset();
        clear_logs();
        for (int i = 0; i < N_REQ; i++) req_angle[9*i +: 9] = 9'($urandom_range(0, 511));
        req_vld = '1;
        repeat (8) @(posedge clk);
        #1 req_vld = 4'b1010;
        repeat (4) @(posedge clk);
        #1 req_vld = '0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk(grant_log.size() == 12, "rr_grant_count", grant_log.size(), 12);
        for (int i = 0; i < 12 && i < grant_log.size(); i++)
            chk(grant_log[i] == ((i < 8) ? (i % 4) : ((i % 2 == 0) ? 1 : 3)),
                "rr_grant", grant_log[i], (i < 8) ? (i % 4) : ((i % 2 == 0) ? 1 : 3));
        for (int i = 0; i < 12 && i < rsp_id_log.size(); i++)
            chk(rsp_id_log[i] == grant_log[i], "rr_rsp_order", rsp_id_log[i], grant_log[i]);

        // en low blocks grants; idle rises LAT cycles after last accept.
        req_vld = '1; en = 1'b0;
        repeat (6) @(posedge clk);
        #1 en = 1'b1;
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        cnt = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (idle) break;
        end
        chk(k == LAT, "idle_rise_delay", k, LAT);
        @(posedge clk); #1 req_vld = '0;

        // Reset mid-flight discards in-flight ops.
        en = 1'b1;
        for (int i = 0; i < 5; i++) issue(0, int'($urandom_range(0, 511)));
        req_vld = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_vld) cnt++;
        end
        chk(cnt == 0, "rsp_after_reset", cnt, 0);
        chk(idle == 1'b1, "idle_after_reset", int'(idle), 1);

        // Randomized traffic against the model.
        @(posedge clk);
        repeat (600) begin
            #1;
            req_vld = N_REQ'($urandom);
            for (int i = 0; i < N_REQ; i++) req_angle[9*i +: 9] = 9'($urandom_range(0, 511));
            en = ($urandom_range(0, 7) != 0);
            @(posedge clk);
        end
        #1 req_vld = '0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_rr_sched.md
# cordic_rr_sched

Round-robin scheduler that shares one fully pipelined 16-stage sin/cos CORDIC datapath among N_REQ requesters. It accepts one integer-degree angle per cycle, reduces it modulo 360 and folds it into the first quadrant. It issues the folded angle into the datapath and tracks each in-flight operation with a tag shift register. It then sign-corrects the returned sin/cos and delivers the result with the originating requester ID. It sits between the requesting engines and the CORDIC pipeline; the pipeline itself is external.

## Interface
Parameters:
- N_REQ, 4 — number of requesters (2..8).
- ID_W, 2 — requester ID width, clog2(N_REQ).
- PIPE_LAT, 18 — cycles from cordic_angle presented to matching cordic_sin/cordic_cos valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  grant enable; low = no new accepts, in-flight ops still drain
- req_vld  in  N_REQ  per-requester request valid
- req_angle  in  9*N_REQ  per-requester angle, unsigned degrees 0..511; slice i = bits [9i+8:9i]
- req_rdy  out  N_REQ  per-requester accept; at most one bit high
- cordic_angle  out  9  folded angle to datapath, 0..90
- cordic_vld  out  1  datapath issue strobe
- cordic_sin  in  32  datapath sin, signed Q16.16
- cordic_cos  in  32  datapath cos, signed Q16.16
- rsp_vld  out  1  response valid, single-cycle pulse
- rsp_id  out  ID_W  requester index of response
- rsp_sin  out  32  signed Q16.16 sin
- rsp_cos  out  32  signed Q16.16 cos
- idle  out  1  high when no op is issued or in flight

## Operation
- Arbitration: req_rdy is combinational. Bit i is high iff en, req_vld[i], and i is the first valid requester at or after pointer ptr, searching cyclically.
- On accept of index g: ptr <= (g+1) mod N_REQ. With no accept, ptr holds. Reset value of ptr is 0.
- Requesters hold req_vld and req_angle stable until req_rdy. No response backpressure exists, so the block never stalls.
- Reduction: a = req_angle; if a >= 360 then a = a - 360 (result 0..151, no second pass needed).
- Quadrant fold: compute folded angle f and quadrant q as follows.
  - 0..90: f = a, q = 0.
  - 91..180: f = 180 - a, q = 1.
  - 181..270: f = a - 180, q = 2.
  - 271..359: f = 360 - a, q = 3.
- Issue register: updated on the accept edge.
  - cordic_angle <= f.
  - cordic_vld <= 1.
  - Tag stage 0 <= {valid = 1, id = g, q}.
  - With no accept: cordic_vld <= 0, tag valid <= 0, cordic_angle holds.
- Tag pipe: PIPE_LAT-stage shift of {valid, id, q[1:0]}, aligned so that the last stage coincides with the cycle cordic_sin/cordic_cos carry that op's result.
- Sign correction, registered into the response stage:
  - q = 0: sin +, cos +.
  - q = 1: sin +, cos -.
  - q = 2: sin -, cos -.
  - q = 3: sin -, cos +.
  - Negation is 32-bit two's complement, wrapping.
- rsp_vld is the last tag stage's valid, registered; rsp_id is that stage's id.
- When rsp_vld is low, rsp_sin and rsp_cos hold their previous values.
- idle = ~cordic_vld & no tag valid bit set in any stage.
- Reset, including mid-operation: all tags invalid, in-flight ops discarded, no response is generated for them.

## Timing
- Reset values: req_rdy = 0 (en is ignored during reset), cordic_angle = 0, cordic_vld = 0, rsp_vld = 0, rsp_id = 0, rsp_sin = 0, rsp_cos = 0, idle = 1.
- Accept in cycle t (req_vld & req_rdy high at edge):
  - cordic_angle/cordic_vld valid in cycle t+1.
  - Datapath result in cycle t+1+PIPE_LAT.
  - rsp_vld in cycle t+2+PIPE_LAT, i.e. t+20 at default.
- Throughput: one accept per cycle; responses return in accept order, one per cycle, with no gaps added.
- en deasserted in cycle t: no accept in t. In-flight ops complete on schedule; idle rises PIPE_LAT+2 cycles after the last accept.
- A requester whose req_vld drops before rdy is simply skipped; ptr is unaffected.

## Test plan
- Single request id 0, angle 30 → rsp_vld exactly 20 cycles after accept, rsp_id = 0, rsp_sin = 32768 ±128, rsp_cos = 56756 ±128.
- Angles 150 / 210 / 330 / 90, one per cycle from id 1 → responses in order:
  - 150: sin +32768, cos -56756.
  - 210: sin -32768, cos -56756.
  - 330: sin -32768, cos +56756.
  - 90: sin 65536, cos 0.
  - All ±128.
- Angle 400 → cordic_angle = 40; rsp_sin = 42125 ±128, rsp_cos = 50203 ±128. Angle 360 → cordic_angle = 0, sin 0, cos 65536.
- All 4 requesters assert continuously → grants 0,1,2,3,0,1… one per cycle; rsp_id follows the same sequence in back-to-back cycles. With only ids 1 and 3 active → alternates 1,3,1,3.
- Issue 5 ops, assert rst_n low for 1 cycle at +8 cycles → no rsp_vld ever produced for those ops; all outputs at reset values; idle = 1.
- en low while all req_vld are high → req_rdy = 0. Ops issued earlier still return at +20; idle rises 20 cycles after the last accept.
